// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit: operand-select
// codes and the destination-register shadow slot record.
package forwarding_hazard_unit_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RET   = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select_logic.sv
// Priority compare of one source register against the EX, MEM and WB shadow
// slots; the nearest producer wins and register 0 never forwards.
module fwd_select_logic
  import forwarding_hazard_unit_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_uses,
  input  logic              i_ex_wr,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_wr,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  output logic [1:0]        o_sel
);

  logic w_live;

  assign w_live = i_uses && (i_src != '0);

  // The i_*_wr inputs already fold together the slot's valid and reg_write bits.
  always_comb begin
    o_sel = FWD_RF;
    if (w_live) begin
      if (i_ex_wr && (i_ex_rd == i_src)) begin
        o_sel = FWD_EXMEM;
      end else if (i_mem_wr && (i_mem_rd == i_src)) begin
        o_sel = FWD_MEMWB;
      end else if (i_wb_wr && (i_wb_rd == i_src)) begin
        o_sel = FWD_RET;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks destination registers through
// EX/MEM/WB/retire and registers operand-select codes at the ID->EX boundary.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [1:0]        o_fwd_sel_a,
  output logic [1:0]        o_fwd_sel_b
);

  slot_t r_ex, r_mem, r_wb, r_ret;
  logic [1:0] r_sel_a, r_sel_b;

  logic w_ex_wr, w_mem_wr, w_wb_wr;
  logic w_load_in_ex, w_src_hit, w_stall, w_bubble;
  logic [1:0] w_sel_a, w_sel_b;

  assign w_ex_wr  = r_ex.valid  && r_ex.reg_write;
  assign w_mem_wr = r_mem.valid && r_mem.reg_write;
  assign w_wb_wr  = r_wb.valid  && r_wb.reg_write;

  // Flush overrides the load-use stall: a killed instruction needs no wait.
  assign w_load_in_ex = w_ex_wr && r_ex.mem_read && (r_ex.rd != '0);
  assign w_src_hit    = (i_id_uses_rs && (i_id_rs == r_ex.rd)) ||
                        (i_id_uses_rt && (i_id_rt == r_ex.rd));
  assign w_stall      = i_id_valid && !i_flush && w_load_in_ex && w_src_hit;
  assign w_bubble     = w_stall || i_flush || !i_id_valid;

  fwd_select_logic u_sel_a (
    .i_src    (i_id_rs),
    .i_uses   (i_id_uses_rs),
    .i_ex_wr  (w_ex_wr),
    .i_ex_rd  (r_ex.rd),
    .i_mem_wr (w_mem_wr),
    .i_mem_rd (r_mem.rd),
    .i_wb_wr  (w_wb_wr),
    .i_wb_rd  (r_wb.rd),
    .o_sel    (w_sel_a)
  );

  fwd_select_logic u_sel_b (
    .i_src    (i_id_rt),
    .i_uses   (i_id_uses_rt),
    .i_ex_wr  (w_ex_wr),
    .i_ex_rd  (r_ex.rd),
    .i_mem_wr (w_mem_wr),
    .i_mem_rd (r_mem.rd),
    .i_wb_wr  (w_wb_wr),
    .i_wb_rd  (r_wb.rd),
    .o_sel    (w_sel_b)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_ret   <= '0;
      r_sel_a <= FWD_RF;
      r_sel_b <= FWD_RF;
    end else begin
      r_ret <= r_wb;
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_bubble) begin
        r_ex    <= '0;
        r_sel_a <= FWD_RF;
        r_sel_b <= FWD_RF;
      end else begin
        r_ex    <= '{valid: 1'b1, rd: i_id_rd, reg_write: i_id_reg_write,
                     mem_read: i_id_mem_read};
        r_sel_a <= w_sel_a;
        r_sel_b <= w_sel_b;
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_fwd_sel_a = r_sel_a;
  assign o_fwd_sel_b = r_sel_b;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: instruction sequences with
// hand-computed stall and operand-select expectations.
module tb_forwarding_hazard_unit;

  logic       clock;
  logic       reset;
  logic       idValid;
  logic [4:0] idRs, idRt, idRd;
  logic       usesRs, usesRt, regWrite, memRead;
  logic       flush;
  logic       stall;
  logic [1:0] selA, selB;

  int checkCount = 0;
  int errorCount = 0;

  forwarding_hazard_unit dut (
    .i_clk          (clock),
    .i_rst          (reset),
    .i_id_valid     (idValid),
    .i_id_rs        (idRs),
    .i_id_rt        (idRt),
    .i_id_uses_rs   (usesRs),
    .i_id_uses_rt   (usesRt),
    .i_id_rd        (idRd),
    .i_id_reg_write (regWrite),
    .i_id_mem_read  (memRead),
    .i_flush        (flush),
    .o_stall        (stall),
    .o_fwd_sel_a    (selA),
    .o_fwd_sel_b    (selB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [1:0] actual,
                             input logic [1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
    end
  endtask

  // Presents one ID-stage instruction shortly after the falling edge.
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic fl);
    @(negedge clock);
    idValid = v;  idRs = rs;  usesRs = urs; idRt = rt; usesRt = urt;
    idRd = rd;    regWrite = rw; memRead = mr; flush = fl;
    #1;
  endtask

  task automatic aluOp(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(1'b1, rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic loadOp(input logic [4:0] rd, input logic [4:0] rs);
    applyStimulus(1'b1, rs, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) bubble();
  endtask

  initial begin
    reset = 1'b1;
    idValid = 0; idRs = 0; idRt = 0; idRd = 0;
    usesRs = 0; usesRt = 0; regWrite = 0; memRead = 0; flush = 0;
    #12;
    checkOutput("reset_stall", {1'b0, stall}, 2'b00);
    checkOutput("reset_selA", selA, 2'b00);
    checkOutput("reset_selB", selB, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back ALU dependency on r3.
    aluOp(5'd3, 5'd1, 5'd2);
    aluOp(5'd8, 5'd3, 5'd6);
    checkOutput("b2b_stall", {1'b0, stall}, 2'b00);
    bubble();
    checkOutput("b2b_selA", selA, 2'b01);
    checkOutput("b2b_selB", selB, 2'b00);

    // Distance 2 on rt=r5.
    drain();
    aluOp(5'd5, 5'd1, 5'd2);
    aluOp(5'd10, 5'd11, 5'd12);
    aluOp(5'd9, 5'd1, 5'd5);
    bubble();
    checkOutput("dist2_selB", selB, 2'b10);

    // Distance 3.
    drain();
    aluOp(5'd5, 5'd1, 5'd2);
    aluOp(5'd10, 5'd11, 5'd12);
    aluOp(5'd13, 5'd14, 5'd15);
    aluOp(5'd9, 5'd1, 5'd5);
    bubble();
    checkOutput("dist3_selB", selB, 2'b11);

    // Distance 4 falls back to the register file.
    drain();
    aluOp(5'd5, 5'd1, 5'd2);
    aluOp(5'd10, 5'd11, 5'd12);
    aluOp(5'd13, 5'd14, 5'd15);
    aluOp(5'd16, 5'd17, 5'd18);
    aluOp(5'd9, 5'd1, 5'd5);
    bubble();
    checkOutput("dist4_selB", selB, 2'b00);

    // Load-use on r7: one stall cycle, bubble in EX, then MEM/WB forward.
    drain();
    loadOp(5'd7, 5'd1);
    aluOp(5'd9, 5'd7, 5'd2);
    checkOutput("lu_stall1", {1'b0, stall}, 2'b01);
    aluOp(5'd9, 5'd7, 5'd2);
    checkOutput("lu_stall2", {1'b0, stall}, 2'b00);
    checkOutput("lu_bubbleA", selA, 2'b00);
    bubble();
    checkOutput("lu_selA", selA, 2'b10);

    // Two producers of r4: nearest wins.
    drain();
    aluOp(5'd4, 5'd1, 5'd2);
    aluOp(5'd4, 5'd1, 5'd2);
    aluOp(5'd9, 5'd4, 5'd2);
    bubble();
    checkOutput("prio_selA", selA, 2'b01);

    // Register 0 never forwards nor stalls.
    drain();
    loadOp(5'd0, 5'd1);
    aluOp(5'd9, 5'd0, 5'd0);
    checkOutput("r0_stall", {1'b0, stall}, 2'b00);
    bubble();
    checkOutput("r0_selA", selA, 2'b00);
    checkOutput("r0_selB", selB, 2'b00);

    // Flush during a load-use hazard.
    drain();
    loadOp(5'd7, 5'd1);
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    checkOutput("fl_stall", {1'b0, stall}, 2'b00);
    bubble();
    checkOutput("fl_selA", selA, 2'b00);
    checkOutput("fl_selB", selB, 2'b00);

    // Reset asserted mid-stall.
    drain();
    loadOp(5'd7, 5'd1);
    aluOp(5'd9, 5'd7, 5'd2);
    checkOutput("rst_pre_stall", {1'b0, stall}, 2'b01);
    reset = 1'b1;
    #1;
    checkOutput("rst_stall", {1'b0, stall}, 2'b00);
    checkOutput("rst_selA", selA, 2'b00);
    checkOutput("rst_selB", selB, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("post_stall", {1'b0, stall}, 2'b00);
    aluOp(5'd10, 5'd11, 5'd12);
    checkOutput("post_heldA", selA, 2'b00);
    aluOp(5'd13, 5'd14, 5'd15);
    checkOutput("post_s1A", selA, 2'b00);
    checkOutput("post_s1B", selB, 2'b00);
    bubble();
    checkOutput("post_s2A", selA, 2'b00);
    checkOutput("post_s2B", selB, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
